sram_ctrl: RTL



---
 rtl/sram_pkg.sv | 15 +
 rtl/sram_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/sram_pkg.sv
// Shared constants and FSM encoding for the SRAM request-side controller.
package sram_pkg;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RSP,
      CLEAR
   } state_e;

endpackage

// File: rtl/sram_ctrl.sv
// Request/response front end for a single-port SRAM with a registered read port,
// plus a hardware sweep that zeroes every location.
module sram_ctrl
   import sram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_start,
   output logic              clr_busy,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rsp_data_q <= rsp_data_d;
         rsp_addr_q <= rsp_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rsp_data_d = rsp_data_q;
      rsp_addr_d = rsp_addr_q;
      req_ready  = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = req_addr;
      mem_din    = req_wdata;
      clr_busy   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // clr_start withholds ready so a coincident request is never accepted
            req_ready = !clr_start;
            if (clr_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else if (req_valid) begin
               if (req_we) begin
                  mem_we = 1'b1;
               end else begin
                  rsp_addr_d = req_addr;
                  state_d    = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            mem_addr   = rsp_addr_q;
            rsp_data_d = mem_dout;
            state_d    = RSP;
         end
         RSP: begin
            mem_addr = rsp_addr_q;
            if (rsp_ready) state_d = IDLE;
         end
         CLEAR: begin
            clr_busy = 1'b1;
            mem_we   = 1'b1;
            mem_addr = cnt_q;
            mem_din  = '0;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         req_ready = 1'b0;
         mem_we    = 1'b0;
         clr_busy  = 1'b0;
      end
   end

   assign rsp_valid = (state_q == RSP);
   assign rsp_data  = rsp_data_q;
   assign rsp_addr  = rsp_addr_q;

endmodule
